score_keeper: RTL
=================

// Module: score_keeper
// PURPOSE
//  Upstream controller for the two score digits of the pong screen. Samples the ball
//  position once per frame and detects goals. Drives frame-wide inc/clr levels into
//  the left and right number instances. Freezes the ball for a serve pause and ends
//  the match at WIN_SCORE.
// PARAMETERS
//  GOAL_LEFT      10'd8    ball_x <= this value is a goal for the right player
//  GOAL_RIGHT     10'd631  ball_x >= this value is a goal for the left player
//                          (must exceed GOAL_LEFT)
//  WIN_SCORE      4'd9     score that ends the match; 1..9, single digit
//  SERVE_FRAMES   8'd60    frames the ball is held after a goal; 0 means 1 frame
//  RESTART_FRAMES 8'd180   frames in OVER before auto-restart (macro only)
// PORTS
//  px_clk       in   1   pixel clock; the only clock
//  reset        in   1   asynchronous, active-low reset
//  frame_start  in   1   one px_clk pulse per frame (vsync edge)
//  ball_x       in   10  ball left-edge X position
//  restart      in   1   request a new match; level, sampled every px_clk
//  inc_left     out  1   held one frame: left score +1 (to the left number's inc)
//  inc_right    out  1   held one frame: right score +1
//  clr_scores   out  1   held one frame: clear both numbers (to their reset)
//  ball_hold    out  1   ball frozen at centre (serve pause or match over)
//  game_over    out  1   match finished
//  winner       out  2   2'b01 left, 2'b10 right, 2'b00 none
// BEHAVIOUR
//  - Evaluation cycle E is the px_clk after frame_start. ball_x is registered on
//    frame_start; the FSM acts at E. All outputs are registered.
//  - Reset: state=CLEAR, clr_scores=1, all other outputs 0.
//  - Internal counters: score_l, score_r (4b), frm_cnt (8b); all reset to 0.
//  - CLEAR: clr_scores=1, scores=0, winner=0. At the next E go to PLAY and
//    set clr_scores=0.
//  - PLAY, at E:
//    - bx<=GOAL_LEFT: inc_right=1, score_r+1.
//    - bx>=GOAL_RIGHT: inc_left=1, score_l+1.
//    - If the new score == WIN_SCORE: go to OVER and set winner. Otherwise go to
//      SERVE with frm_cnt=0. No goal: stay in PLAY.
//  - inc_* drop at the next E, so each pulse is exactly one frame wide. At most one
//    inc per E.
//  - SERVE: ball_hold=1; goals ignored; frm_cnt+1 each E; go to PLAY at the E where
//    frm_cnt >= SERVE_FRAMES-1, dropping ball_hold.
//  - OVER: ball_hold=1, game_over=1, winner held; goals ignored; scores frozen.
//  - restart=1 in any state except CLEAR: go to CLEAR on the next px_clk and
//    clear inc_*, ball_hold, game_over, winner.
//    - restart beats a goal in the same cycle; no inc is issued.
//    - CLEAR still ends only at a later E.
//  - Goal while inc_* is still high: impossible, because PLAY is left on every goal.
//  - frame_start during reset: ignored. Reset mid-frame returns to CLEAR at once.
// CONFIGURATION
//  SCORE_KEEPER_AUTO_RESTART_EN defined:
//    - OVER counts E pulses in frm_cnt. At frm_cnt >= RESTART_FRAMES-1 it goes to
//      CLEAR as if restart had been asserted.
//    - restart still works earlier.
//  Not defined: OVER is left only by restart or reset; RESTART_FRAMES is unused.
// TESTING
//  1. Release reset, then 2 frame_starts:
//     -> clr_scores=1 until the first E, then 0; state PLAY, ball_hold=0.
//  2. ball_x=5 at frame_start:
//     -> inc_right=1 from E for exactly one frame, then ball_hold=1 for 60 frames,
//        then ball_hold=0.
//  3. ball_x=631 on nine separated serves:
//     -> 9 inc_left pulses; after the 9th, game_over=1, winner=01, ball_hold=1.
//     -> A further ball_x=0 gives no inc.
//  4. restart in the same cycle as a goal E:
//     -> no inc; clr_scores=1 next cycle; PLAY after the next E.
//  5. Assert reset mid-SERVE:
//     -> ball_hold=0 and clr_scores=1 immediately, without waiting for px_clk.
//  6. With SCORE_KEEPER_AUTO_RESTART_EN, RESTART_FRAMES=3:
//     -> OVER leaves after 3 E pulses; clr_scores=1.
//     -> Without the macro, game_over stays high after 200 frames.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: pong score controller. It samples ball_x once per frame, detects
// goals, and drives frame-wide inc/clr levels into the two score-digit instances.
// After a goal it holds the ball for a serve pause, and it ends the match at WIN_SCORE.
// Optional feature macro: SCORE_KEEPER_AUTO_RESTART_EN. When it is defined, OVER
// returns to CLEAR on its own after RESTART_FRAMES evaluation cycles.
module score_keeper #(
  parameter logic [9:0] GOAL_LEFT      = 10'd8,
  parameter logic [9:0] GOAL_RIGHT     = 10'd631,
  parameter logic [3:0] WIN_SCORE      = 4'd9,
  parameter logic [7:0] SERVE_FRAMES   = 8'd60,
  parameter logic [7:0] RESTART_FRAMES = 8'd180
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [9:0] ball_x,
  input  logic       restart,
  output logic       inc_left,
  output logic       inc_right,
  output logic       clr_scores,
  output logic       ball_hold,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_PLAY  = 2'd1,
    ST_SERVE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // A frame count of 0 still means one frame of serve pause.
  localparam logic [7:0] SERVE_LAST = (SERVE_FRAMES == 8'd0) ? 8'd0 : SERVE_FRAMES - 8'd1;

  state_t     r_state, w_state_nxt;
  logic [9:0] r_bx_p0;
  logic       r_eval;
  logic [3:0] r_score_l, r_score_r, w_score_l_nxt, w_score_r_nxt;
  logic [7:0] r_frm_cnt, w_frm_cnt_nxt;
  logic       r_inc_l, r_inc_r, r_clr, r_hold, r_over;
  logic       w_inc_l_nxt, w_inc_r_nxt, w_clr_nxt, w_hold_nxt, w_over_nxt;
  logic [1:0] r_winner, w_winner_nxt;
  logic [3:0] w_score_l_inc, w_score_r_inc;
  logic       w_over_done;

  assign w_score_l_inc = r_score_l + 4'd1;
  assign w_score_r_inc = r_score_r + 4'd1;

`ifdef SCORE_KEEPER_AUTO_RESTART_EN
  localparam logic [7:0] RESTART_LAST = (RESTART_FRAMES == 8'd0) ? 8'd0 : RESTART_FRAMES - 8'd1;
  assign w_over_done = (r_frm_cnt >= RESTART_LAST);
`else
  // Without auto-restart, OVER is left only by restart or reset.
  assign w_over_done = 1'b0;
  if (RESTART_FRAMES == 8'd0) begin : g_restart_unused
  end
`endif

  // Ball position sample point: data only, so it has no reset.
  always_ff @(posedge px_clk) begin
    if (frame_start) r_bx_p0 <= ball_x;
  end

  // Evaluation strobe: marks the cycle after frame_start. Reset so that pulses seen during reset are dropped.
  always_ff @(posedge px_clk or negedge reset) begin
    if (!reset) r_eval <= 1'b0;
    else        r_eval <= frame_start;
  end

  // State, counters and registered outputs.
  always_ff @(posedge px_clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_CLEAR;
      r_score_l <= 4'd0;
      r_score_r <= 4'd0;
      r_frm_cnt <= 8'd0;
      r_inc_l   <= 1'b0;
      r_inc_r   <= 1'b0;
      r_clr     <= 1'b1;
      r_hold    <= 1'b0;
      r_over    <= 1'b0;
      r_winner  <= 2'b00;
    end else begin
      r_state   <= w_state_nxt;
      r_score_l <= w_score_l_nxt;
      r_score_r <= w_score_r_nxt;
      r_frm_cnt <= w_frm_cnt_nxt;
      r_inc_l   <= w_inc_l_nxt;
      r_inc_r   <= w_inc_r_nxt;
      r_clr     <= w_clr_nxt;
      r_hold    <= w_hold_nxt;
      r_over    <= w_over_nxt;
      r_winner  <= w_winner_nxt;
    end
  end

  // Next-state and next-output logic. restart overrides any goal or timeout in the same cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_score_l_nxt = r_score_l;
    w_score_r_nxt = r_score_r;
    w_frm_cnt_nxt = r_frm_cnt;
    w_inc_l_nxt   = r_inc_l;
    w_inc_r_nxt   = r_inc_r;
    w_clr_nxt     = r_clr;
    w_hold_nxt    = r_hold;
    w_over_nxt    = r_over;
    w_winner_nxt  = r_winner;

    if ((restart && (r_state != ST_CLEAR)) ||
        (r_eval && (r_state == ST_OVER) && w_over_done)) begin
      w_state_nxt   = ST_CLEAR;
      w_clr_nxt     = 1'b1;
      w_inc_l_nxt   = 1'b0;
      w_inc_r_nxt   = 1'b0;
      w_hold_nxt    = 1'b0;
      w_over_nxt    = 1'b0;
      w_winner_nxt  = 2'b00;
      w_score_l_nxt = 4'd0;
      w_score_r_nxt = 4'd0;
      w_frm_cnt_nxt = 8'd0;
    end else if (r_eval) begin
      // An inc pulse lasts from one evaluation cycle to the next.
      w_inc_l_nxt = 1'b0;
      w_inc_r_nxt = 1'b0;
      unique case (r_state)
        ST_CLEAR: begin
          w_state_nxt   = ST_PLAY;
          w_clr_nxt     = 1'b0;
          w_score_l_nxt = 4'd0;
          w_score_r_nxt = 4'd0;
          w_winner_nxt  = 2'b00;
        end
        ST_PLAY: begin
          if (r_bx_p0 <= GOAL_LEFT) begin
            w_inc_r_nxt   = 1'b1;
            w_score_r_nxt = w_score_r_inc;
            w_hold_nxt    = 1'b1;
            w_frm_cnt_nxt = 8'd0;
            if (w_score_r_inc == WIN_SCORE) begin
              w_state_nxt  = ST_OVER;
              w_over_nxt   = 1'b1;
              w_winner_nxt = 2'b10;
            end else begin
              w_state_nxt = ST_SERVE;
            end
          end else if (r_bx_p0 >= GOAL_RIGHT) begin
            w_inc_l_nxt   = 1'b1;
            w_score_l_nxt = w_score_l_inc;
            w_hold_nxt    = 1'b1;
            w_frm_cnt_nxt = 8'd0;
            if (w_score_l_inc == WIN_SCORE) begin
              w_state_nxt  = ST_OVER;
              w_over_nxt   = 1'b1;
              w_winner_nxt = 2'b01;
            end else begin
              w_state_nxt = ST_SERVE;
            end
          end
        end
        ST_SERVE: begin
          if (r_frm_cnt >= SERVE_LAST) begin
            w_state_nxt = ST_PLAY;
            w_hold_nxt  = 1'b0;
          end else begin
            w_frm_cnt_nxt = r_frm_cnt + 8'd1;
          end
        end
        ST_OVER: begin
          w_frm_cnt_nxt = r_frm_cnt + 8'd1;
        end
        default: begin
          w_state_nxt = ST_CLEAR;
          w_clr_nxt   = 1'b1;
        end
      endcase
    end
  end

  assign inc_left   = r_inc_l;
  assign inc_right  = r_inc_r;
  assign clr_scores = r_clr;
  assign ball_hold  = r_hold;
  assign game_over  = r_over;
  assign winner     = r_winner;

endmodule
